// File: rtl/mem_spi_flash_responder_if.sv
// Serial flash link between a SPI/QSPI controller and the flash responder.
interface mem_spi_flash_responder_if;
  logic       sclk;
  logic       cs_n;
  logic [3:0] in_io;
  logic [3:0] out_io;
  logic [3:0] io_ena;

  modport master (
    output sclk,
    output cs_n,
    output in_io,
    input  out_io,
    input  io_ena
  );

  modport slave (
    input  sclk,
    input  cs_n,
    input  in_io,
    output out_io,
    output io_ena
  );
endinterface

// File: rtl/mem_spi_flash_responder.sv
// SPI/QSPI NOR-flash responder: decodes opcodes from oversampled serial pins,
// holds a small byte array plus WEL/QE status bits, returns single or quad data.
module mem_spi_flash_responder #(
  parameter int unsigned DEPTH     = 32,
  parameter logic [7:0]  INIT_BYTE = 8'hFF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  mem_spi_flash_responder_if.slave   bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 5;

  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR1 = 8'h05;
  localparam logic [7:0] OP_RDSR2 = 8'h35;
  localparam logic [7:0] OP_WRSR2 = 8'h31;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_QREAD = 8'h6B;
  localparam logic [7:0] OP_PP    = 8'h02;

  typedef enum logic [3:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_TX_SINGLE,
    ST_TX_QUAD, ST_RX_DATA, ST_RX_STAT, ST_IGNORE
  } state_e;

  typedef enum logic [1:0] {WOP_NONE, WOP_SET, WOP_CLR} wel_op_e;
  typedef enum logic [1:0] {SRC_MEM, SRC_SR1, SRC_SR2} src_e;

  logic [1:0]    r_sclk_s;
  logic          r_sclk_d;
  logic [1:0]    r_cs_s;
  logic          r_cs_d;
  logic [3:0]    r_io_s1;
  logic [3:0]    r_io_s2;

  state_e        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [6:0]    r_sh, w_sh_nxt;
  logic [7:0]    r_op, w_op_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic [7:0]    r_tx, w_tx_nxt;
  src_e          r_src, w_src_nxt;
  logic [3:0]    r_out_io, w_out_nxt;
  logic [3:0]    r_io_ena, w_ena_nxt;
  logic          r_wel, w_wel_nxt;
  logic          r_qe, w_qe_nxt;
  wel_op_e       r_wel_op, w_welop_nxt;
  logic [7:0]    r_mem [DEPTH];

  logic          w_mem_we;
  logic [7:0]    w_mem_wdata;
  logic          w_rise, w_fall, w_cs, w_mosi;
  logic [7:0]    w_byte;
  logic [AW-1:0] w_addr_shift, w_addr_inc;
  logic [CW-1:0] w_cnt_inc;
  logic [7:0]    w_reload;
  logic          w_unused_io;

  assign w_cs         = r_cs_s[1];
  assign w_rise       = r_sclk_s[1] & ~r_sclk_d;
  assign w_fall       = ~r_sclk_s[1] & r_sclk_d;
  assign w_mosi       = r_io_s2[0];
  assign w_unused_io  = ^r_io_s2[3:1];
  assign w_byte       = {r_sh, w_mosi};
  assign w_addr_shift = AW'({r_addr, w_mosi});
  assign w_addr_inc   = r_addr + AW'(1);
  assign w_cnt_inc    = r_cnt + CW'(1);

  assign bus.out_io = r_out_io;
  assign bus.io_ena = r_io_ena;

  // Two-flop synchronizers plus one delayed copy for edge detection; cs
  // resets low so a reset inside a transaction waits for a real cs_n rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_s <= 2'b00;
      r_sclk_d <= 1'b0;
      r_cs_s   <= 2'b00;
      r_cs_d   <= 1'b0;
      r_io_s1  <= 4'h0;
      r_io_s2  <= 4'h0;
    end else begin
      r_sclk_s <= {r_sclk_s[0], bus.sclk};
      r_sclk_d <= r_sclk_s[1];
      r_cs_s   <= {r_cs_s[0], bus.cs_n};
      r_cs_d   <= r_cs_s[1];
      r_io_s1  <= bus.in_io;
      r_io_s2  <= r_io_s1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Datapath, status and registered pin outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_sh     <= '0;
      r_op     <= '0;
      r_addr   <= '0;
      r_tx     <= '0;
      r_src    <= SRC_MEM;
      r_out_io <= 4'h0;
      r_io_ena <= 4'h0;
      r_wel    <= 1'b0;
      r_qe     <= 1'b0;
      r_wel_op <= WOP_NONE;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_sh     <= w_sh_nxt;
      r_op     <= w_op_nxt;
      r_addr   <= w_addr_nxt;
      r_tx     <= w_tx_nxt;
      r_src    <= w_src_nxt;
      r_out_io <= w_out_nxt;
      r_io_ena <= w_ena_nxt;
      r_wel    <= w_wel_nxt;
      r_qe     <= w_qe_nxt;
      r_wel_op <= w_welop_nxt;
    end
  end

  // Storage array; programming can only clear bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= INIT_BYTE;
    end else if (w_mem_we) begin
      r_mem[r_addr] <= w_mem_wdata;
    end
  end

  // Next byte to stream once the current one is shifted out.
  always_comb begin
    w_reload = r_mem[w_addr_inc];
    case (r_src)
      SRC_SR1: w_reload = {6'b0, r_wel, 1'b0};
      SRC_SR2: w_reload = {6'b0, r_qe, 1'b0};
      default: w_reload = r_mem[w_addr_inc];
    endcase
  end

  // Next-state and datapath update, driven by synchronized sclk edges.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sh_nxt    = r_sh;
    w_op_nxt    = r_op;
    w_addr_nxt  = r_addr;
    w_tx_nxt    = r_tx;
    w_src_nxt   = r_src;
    w_out_nxt   = r_out_io;
    w_ena_nxt   = r_io_ena;
    w_wel_nxt   = r_wel;
    w_qe_nxt    = r_qe;
    w_welop_nxt = r_wel_op;
    w_mem_we    = 1'b0;
    w_mem_wdata = r_mem[r_addr] & w_byte;

    if (w_cs) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_out_nxt   = 4'h0;
      w_ena_nxt   = 4'h0;
      w_welop_nxt = WOP_NONE;
      case (r_wel_op)
        WOP_SET: w_wel_nxt = 1'b1;
        WOP_CLR: w_wel_nxt = 1'b0;
        default: w_wel_nxt = r_wel;
      endcase
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_cs_d) begin
            w_state_nxt = ST_CMD;
            w_cnt_nxt   = '0;
          end
        end
        ST_CMD: begin
          if (w_rise) begin
            w_sh_nxt  = w_byte[6:0];
            w_cnt_nxt = w_cnt_inc;
            if (r_cnt == CW'(7)) begin
              w_cnt_nxt = '0;
              w_op_nxt  = w_byte;
              case (w_byte)
                OP_WREN: begin
                  w_welop_nxt = WOP_SET;
                  w_state_nxt = ST_IGNORE;
                end
                OP_WRDI: begin
                  w_welop_nxt = WOP_CLR;
                  w_state_nxt = ST_IGNORE;
                end
                OP_RDSR1: begin
                  w_tx_nxt    = {6'b0, r_wel, 1'b0};
                  w_src_nxt   = SRC_SR1;
                  w_state_nxt = ST_TX_SINGLE;
                end
                OP_RDSR2: begin
                  w_tx_nxt    = {6'b0, r_qe, 1'b0};
                  w_src_nxt   = SRC_SR2;
                  w_state_nxt = ST_TX_SINGLE;
                end
                OP_WRSR2: begin
                  w_welop_nxt = WOP_CLR;
                  w_state_nxt = ST_RX_STAT;
                end
                OP_READ, OP_PP: w_state_nxt = ST_ADDR;
                OP_QREAD:       w_state_nxt = r_qe ? ST_ADDR : ST_IGNORE;
                default:        w_state_nxt = ST_IGNORE;
              endcase
            end
          end
        end
        ST_ADDR: begin
          if (w_rise) begin
            w_addr_nxt = w_addr_shift;
            w_cnt_nxt  = w_cnt_inc;
            if (r_cnt == CW'(23)) begin
              w_cnt_nxt = '0;
              case (r_op)
                OP_READ: begin
                  w_tx_nxt    = r_mem[w_addr_shift];
                  w_src_nxt   = SRC_MEM;
                  w_state_nxt = ST_TX_SINGLE;
                end
                OP_QREAD: w_state_nxt = ST_DUMMY;
                default: begin
                  w_welop_nxt = WOP_CLR;
                  w_state_nxt = ST_RX_DATA;
                end
              endcase
            end
          end
        end
        ST_DUMMY: begin
          if (w_rise) begin
            w_cnt_nxt = w_cnt_inc;
            if (r_cnt == CW'(7)) begin
              w_cnt_nxt   = '0;
              w_tx_nxt    = r_mem[r_addr];
              w_src_nxt   = SRC_MEM;
              w_state_nxt = ST_TX_QUAD;
            end
          end
        end
        ST_TX_SINGLE: begin
          if (w_fall) begin
            w_out_nxt = {2'b00, r_tx[7], 1'b0};
            w_ena_nxt = 4'b0010;
            if (r_cnt == CW'(7)) begin
              w_cnt_nxt = '0;
              w_tx_nxt  = w_reload;
              if (r_src == SRC_MEM) w_addr_nxt = w_addr_inc;
            end else begin
              w_cnt_nxt = w_cnt_inc;
              w_tx_nxt  = {r_tx[6:0], 1'b0};
            end
          end
        end
        ST_TX_QUAD: begin
          if (w_fall) begin
            w_out_nxt = r_tx[7:4];
            w_ena_nxt = 4'b1111;
            if (r_cnt[0]) begin
              w_cnt_nxt  = '0;
              w_tx_nxt   = r_mem[w_addr_inc];
              w_addr_nxt = w_addr_inc;
            end else begin
              w_cnt_nxt = CW'(1);
              w_tx_nxt  = {r_tx[3:0], 4'h0};
            end
          end
        end
        ST_RX_DATA: begin
          if (w_rise) begin
            w_sh_nxt  = w_byte[6:0];
            w_cnt_nxt = w_cnt_inc;
            if (r_cnt == CW'(7)) begin
              w_cnt_nxt  = '0;
              w_mem_we   = r_wel;
              w_addr_nxt = w_addr_inc;
            end
          end
        end
        ST_RX_STAT: begin
          if (w_rise) begin
            w_sh_nxt  = w_byte[6:0];
            w_cnt_nxt = w_cnt_inc;
            if (r_cnt == CW'(7)) begin
              w_cnt_nxt   = '0;
              w_state_nxt = ST_IGNORE;
              if (r_wel) w_qe_nxt = w_byte[1];
            end
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_spi_flash_responder.sv
// Bench for mem_spi_flash_responder: directed flash transactions plus a
// randomized phase, checked against a transaction-level flash model.
module tb_mem_spi_flash_responder;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned HALF  = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_spi_flash_responder_if bus();

  mem_spi_flash_responder #(.DEPTH(DEPTH), .INIT_BYTE(8'hFF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] m_mem [DEPTH];
  logic       m_wel;
  logic       m_qe;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int idx(input logic [23:0] a, input int i);
    return (int'(a) + i) % int'(DEPTH);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = 8'hFF;
    m_wel = 1'b0;
    m_qe  = 1'b0;
  endtask

  // One sclk period; pins sampled at the end of the low phase.
  task automatic sclk_cycle(input logic [3:0] drv, output logic [3:0] o, output logic [3:0] e);
    bus.in_io = drv;
    repeat (HALF) @(negedge clk);
    o = bus.out_io;
    e = bus.io_ena;
    bus.sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    bus.sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [7:0] rx,
                           output logic [3:0] ena_or, output logic [3:0] ena_and,
                           output logic [3:0] out_or);
    logic [3:0] o, e;
    rx = 8'h00; ena_or = 4'h0; ena_and = 4'hF; out_or = 4'h0;
    for (int i = 7; i >= 0; i--) begin
      sclk_cycle({3'b000, b[i]}, o, e);
      rx[i]   = o[1];
      ena_or  = ena_or | e;
      ena_and = ena_and & e;
      out_or  = out_or | o;
    end
  endtask

  task automatic send_cmd(input string tag, input logic [7:0] b);
    logic [7:0] rx;
    logic [3:0] eo, ea, oo;
    send_byte(b, rx, eo, ea, oo);
    check(tag, eo, 4'h0);
  endtask

  task automatic send_addr(input logic [23:0] a);
    send_cmd("addr_ena", a[23:16]);
    send_cmd("addr_ena", a[15:8]);
    send_cmd("addr_ena", a[7:0]);
  endtask

  task automatic cs_begin();
    bus.cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (HALF) @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (3) @(negedge clk);
    check("cs_rise_ena", bus.io_ena, 4'h0);
    check("cs_rise_out", bus.out_io, 4'h0);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_simple(input logic [7:0] op);
    cs_begin();
    send_cmd("simple_ena", op);
    cs_end();
    if (op == 8'h06) m_wel = 1'b1;
    if (op == 8'h04) m_wel = 1'b0;
  endtask

  task automatic do_rdsr(input logic [7:0] op);
    logic [7:0] rx, exp;
    logic [3:0] eo, ea, oo;
    exp = (op == 8'h05) ? {6'b0, m_wel, 1'b0} : {6'b0, m_qe, 1'b0};
    cs_begin();
    send_cmd("rdsr_cmd_ena", op);
    for (int k = 0; k < 2; k++) begin
      send_byte(8'h00, rx, eo, ea, oo);
      check("rdsr_data", rx, exp);
      check("rdsr_ena", {eo, ea}, 8'h22);
      check("rdsr_unused_pins", oo & 4'b1101, 4'h0);
    end
    cs_end();
  endtask

  task automatic do_wrsr2(input logic [7:0] v);
    cs_begin();
    send_cmd("wrsr2_ena", 8'h31);
    send_cmd("wrsr2_ena", v);
    cs_end();
    if (m_wel) m_qe = v[1];
    m_wel = 1'b0;
  endtask

  task automatic do_prog(input logic [23:0] a, input logic [31:0] d, input int n);
    cs_begin();
    send_cmd("pp_ena", 8'h02);
    send_addr(a);
    for (int i = 0; i < n; i++) send_cmd("pp_data_ena", d[31-8*i -: 8]);
    cs_end();
    if (m_wel)
      for (int i = 0; i < n; i++) m_mem[idx(a, i)] = m_mem[idx(a, i)] & d[31-8*i -: 8];
    m_wel = 1'b0;
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    logic [7:0] rx;
    logic [3:0] eo, ea, oo;
    cs_begin();
    send_cmd("read_cmd_ena", 8'h03);
    send_addr(a);
    for (int i = 0; i < n; i++) begin
      send_byte(8'($urandom), rx, eo, ea, oo);
      check("read_data", rx, m_mem[idx(a, i)]);
      check("read_ena", {eo, ea}, 8'h22);
    end
    cs_end();
  endtask

  task automatic do_qread(input logic [23:0] a, input int n);
    logic [3:0] o, e, eo, hi;
    cs_begin();
    send_cmd("qread_cmd_ena", 8'h6B);
    send_addr(a);
    eo = 4'h0;
    if (!m_qe) begin
      for (int k = 0; k < 16; k++) begin
        sclk_cycle(4'h0, o, e);
        eo = eo | e;
      end
      check("qread_noqe_ena", eo, 4'h0);
    end else begin
      for (int k = 0; k < 8; k++) begin
        sclk_cycle(4'h0, o, e);
        eo = eo | e;
      end
      check("qread_dummy_ena", eo, 4'h0);
      for (int i = 0; i < n; i++) begin
        sclk_cycle(4'h0, hi, e);
        check("qread_ena_hi", e, 4'hF);
        sclk_cycle(4'h0, o, e);
        check("qread_ena_lo", e, 4'hF);
        check("qread_data", {hi, o}, m_mem[idx(a, i)]);
      end
    end
    cs_end();
  endtask

  initial begin
    logic [3:0] o, e, eo;
    logic [7:0] rx;
    logic [3:0] ea, oo;
    logic [23:0] a;

    rst_n = 1'b0;
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.in_io = 4'h0;
    model_reset();
    repeat (4) @(negedge clk);
    check("reset_out", bus.out_io, 4'h0);
    check("reset_ena", bus.io_ena, 4'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    do_rdsr(8'h05);
    do_rdsr(8'h35);

    do_simple(8'h06);
    do_prog(24'h000005, {8'h5A, 8'h3C, 16'h0}, 2);
    do_read(24'h000004, 4);
    check("pp_fixed_5", m_mem[5], 8'h5A);
    do_rdsr(8'h05);

    do_prog(24'h000010, 32'h0, 1);
    do_read(24'h000010, 1);
    do_simple(8'h06);
    do_prog(24'h000010, {8'hF0, 24'h0}, 1);
    do_simple(8'h06);
    do_prog(24'h000010, {8'h3C, 24'h0}, 1);
    do_read(24'h000010, 1);

    do_simple(8'h06);
    do_rdsr(8'h05);
    do_simple(8'h04);
    do_rdsr(8'h05);

    do_qread(24'h00001E, 3);
    do_simple(8'h06);
    do_wrsr2(8'h02);
    do_rdsr(8'h35);
    do_simple(8'h06);
    do_prog(24'h00001E, {8'hA5, 8'h7E, 8'hC3, 8'h00}, 3);
    do_qread(24'h00001E, 3);

    // Unknown opcode followed by idle clocks
    cs_begin();
    send_cmd("unk_cmd_ena", 8'hAB);
    eo = 4'h0;
    for (int k = 0; k < 32; k++) begin
      sclk_cycle(4'($urandom), o, e);
      eo = eo | e;
    end
    check("unk_ena", eo, 4'h0);
    cs_end();
    do_rdsr(8'h05);
    do_rdsr(8'h35);
    do_read(24'h00001D, 4);

    // Program byte abandoned after four bits
    do_simple(8'h06);
    cs_begin();
    send_cmd("part_ena", 8'h02);
    send_addr(24'h000008);
    for (int k = 0; k < 4; k++) sclk_cycle(4'h0, o, e);
    repeat (HALF) @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (3) @(negedge clk);
    check("part_cs_ena", bus.io_ena, 4'h0);
    repeat (4) @(negedge clk);
    m_wel = 1'b0;
    do_read(24'h000008, 1);
    do_rdsr(8'h05);

    // Reset pulsed in the middle of a READ
    cs_begin();
    send_cmd("rst_cmd_ena", 8'h03);
    send_addr(24'h00001E);
    send_byte(8'h00, rx, eo, ea, oo);
    check("rst_pre_data", rx, m_mem[30]);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out", bus.out_io, 4'h0);
    check("rst_mid_ena", bus.io_ena, 4'h0);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (HALF) @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (6) @(negedge clk);
    do_read(24'h00001E, 3);
    do_rdsr(8'h35);

    // Randomized transactions
    do_simple(8'h06);
    do_wrsr2(8'h02);
    for (int t = 0; t < 24; t++) begin
      a = 24'($urandom);
      case ($urandom_range(0, 4))
        0: begin
          do_simple(8'h06);
          do_prog(a, $urandom, int'($urandom_range(1, 4)));
        end
        1: do_prog(a, $urandom, int'($urandom_range(1, 2)));
        2: do_read(a, int'($urandom_range(1, 4)));
        3: do_qread(a, int'($urandom_range(1, 3)));
        default: begin
          do_simple(($urandom_range(0, 1) == 0) ? 8'h06 : 8'h04);
          do_rdsr(8'h05);
        end
      endcase
    end
    do_read(24'h000000, int'(DEPTH));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_spi_flash_responder.md
# mem_spi_flash_responder

Synthesizable SPI/QSPI NOR-flash responder: the target end of the flash link driven by `mem_spi_controller`. It decodes opcodes, addresses and data from the serial pins, holds a small byte array and two status registers, and returns read data in single or quad mode. It serves as the on-chip flash stand-in for system simulation and FPGA bring-up of the memory interface.

## Interface
Parameters:
- `DEPTH`, 32: bytes of storage; a power of two, at most 256. Address bits above log2(DEPTH) are ignored.
- `INIT_BYTE`, 8'hFF: reset value of every storage byte.

Ports:
- `clk`  in  1  system clock. One clock only; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sclk`  in  1  SPI clock from the controller, mode 0. Asynchronous to `clk`.
- `cs_n`  in  1  chip select, active low. Asynchronous to `clk`.
- `in_io`  in  4  IO pins from the controller. `in_io[0]` is MOSI.
- `out_io`  out  4  IO pins to the controller. `out_io[1]` is MISO in single mode.
- `io_ena`  out  4  per-pin output enable, 1 = drive.

## Operation
- `sclk`, `cs_n` and `in_io` each pass through a 2-FF synchronizer. Edges of `sclk` are detected from the synchronized copies.
- Bits are sampled on a detected rise of `sclk` and shifted out on a detected fall. All transfers are MSB first.
- In quad mode, `out_io[3:0]` carries byte[7:4] first, then byte[3:0].
- Deassertion of `cs_n`, from any state, returns the FSM to IDLE and clears all counters and `io_ena`.
- FSM states: IDLE, CMD, ADDR, DUMMY, TX_SINGLE, TX_QUAD, RX_DATA, RX_STAT, IGNORE.
- IDLE → CMD on `cs_n` falling. CMD shifts 8 bits, then decodes:
  - 0x06 WREN: sets WEL at `cs_n` rise. Then IGNORE.
  - 0x04 WRDI: clears WEL at `cs_n` rise. Then IGNORE.
  - 0x05 RDSR1: → TX_SINGLE, returning {6'b0, WEL, 1'b0} (BUSY is always 0). The value repeats while clocks continue.
  - 0x35 RDSR2: → TX_SINGLE, returning {6'b0, QE, 1'b0}. The value repeats.
  - 0x31 WRSR2: → RX_STAT. On the 8th bit, if WEL=1 then QE takes data[1]; the write is dropped otherwise. WEL clears at `cs_n` rise.
  - 0x03 READ: → ADDR (24 bits) → TX_SINGLE, streaming mem[addr], addr+1, and so on.
  - 0x6B QUAD OUTPUT READ: if QE=0 → IGNORE. Otherwise ADDR → DUMMY (8 `sclk` rises) → TX_QUAD.
  - 0x02 PAGE PROGRAM: → ADDR → RX_DATA. For each complete byte, if WEL=1 then mem[addr] ← mem[addr] & data (flash AND semantics), then addr+1. WEL clears at `cs_n` rise. A partial final byte is discarded.
  - Any other opcode: → IGNORE until `cs_n` rises.
- Address arithmetic is modulo DEPTH. Reads and programs wrap from DEPTH-1 to 0.
- `io_ena` by state:
  - 4'b0010 in TX_SINGLE.
  - 4'b1111 in TX_QUAD.
  - 4'b0000 everywhere else.
- `out_io` bits not enabled are driven 0.

## Timing
- Reset values:
  - `out_io` = 0, `io_ena` = 0.
  - WEL = 0, QE = 0.
  - FSM in IDLE.
  - All storage bytes = INIT_BYTE.
- `sclk` high and low phases must each be ≥ 4 `clk` periods, which covers 2-FF plus edge-detect latency of 3 `clk`.
- Edge to `out_io` update: 3 `clk` after the real `sclk` fall.
- First data bit timing:
  - READ and RDSRx: the MSB of the first byte is driven on the `sclk` fall after the last address or opcode bit is sampled (fall after rise 32 for READ, after rise 8 for RDSRx). `io_ena` asserts on that same fall.
  - Quad: the first nibble is driven on the fall after the 8th dummy rise. Each byte takes 2 `sclk` cycles.
- Memory write happens in the `clk` cycle after the 8th data bit is sampled. A following READ in a new transaction sees it.
- `cs_n` rise: `io_ena` returns to 0 within 3 `clk`. A pending WEL update applies in the same cycle.
- `rst_n` asserted mid-transaction clears state immediately. The bus is re-entered only on the next `cs_n` fall after the synchronized `cs_n` is seen high.

## Test plan
- Reset, then RDSR1 and RDSR2: the responses are 0x00 and 0x00, with `io_ena`=4'b0010 only during the response byte.
- WREN, then PAGE PROGRAM to addr 0x000005 with 0x5A, 0x3C, then READ from 0x000004 for 4 bytes → 0xFF, 0x5A, 0x3C, 0xFF. RDSR1 afterwards → 0x00 (WEL cleared).
- PAGE PROGRAM without WREN to addr 0x10 with 0x00 → READ returns 0xFF. Program with WREN 0xF0, then with WREN 0x3C → READ returns 0x30.
- 0x6B with QE=0 → `io_ena` stays 0. Then WREN, WRSR2 0x02, RDSR2 → 0x02. Then 0x6B from addr 0x1E (DEPTH=32) reads mem[0x1E], mem[0x1F], mem[0x00] as nibbles on `out_io[3:0]`.
- Unknown opcode 0xAB followed by 32 clocks → `io_ena` stays 0 and there are no state changes. A subsequent READ works.
- `cs_n` raised after 4 bits of a program byte → the byte is not written and `io_ena`=0 within 3 `clk`. `rst_n` pulsed mid-READ → outputs go to 0 immediately and the next READ is correct.
